// File: rtl/exp_sub_arbiter.sv
// Two-requester round-robin arbiter sharing one (a - b) subtractor, with a single registered result slot.
// Optional per-requester saturating grant counters are enabled by defining EXP_SUB_STATS_EN.
module exp_sub_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_diff,
    output logic             rsp_co
`ifdef EXP_SUB_STATS_EN
    ,
    output logic [7:0]       gnt_cnt0,
    output logic [7:0]       gnt_cnt1
`endif
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             last_gnt_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_diff_q;
    logic             rsp_co_q;

    logic             accept_ok;
    logic             gnt_fire;
    logic             gnt_idx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0]   sub_res;

    // Returns {carry_out, diff} of a + ~b + 1 using generate/propagate carry terms.
    function automatic logic [WIDTH:0] sub_co(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g, p, d;
        logic [WIDTH:0]   c;
        g    = a & ~b;
        p    = a ^ ~b;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            d[i]   = p[i] ^ c[i];
        end
        return {c[WIDTH], d};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Grant selection, readies and next state
    always_comb begin
        state_d    = state_q;
        accept_ok  = (state_q == IDLE) || rsp_ready;
        gnt_idx    = (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;
        gnt_fire   = rst_n && accept_ok && (req0_valid || req1_valid);
        req0_ready = gnt_fire && !gnt_idx;
        req1_ready = gnt_fire && gnt_idx;
        if (gnt_fire) begin
            state_d = HOLD;
        end else if ((state_q == HOLD) && rsp_ready) begin
            state_d = IDLE;
        end
    end

    // Shared subtractor fed by the granted operands
    always_comb begin
        op_a    = gnt_idx ? req1_a : req0_a;
        op_b    = gnt_idx ? req1_b : req0_b;
        sub_res = sub_co(op_a, op_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // last_gnt resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            rsp_id_q   <= 1'b0;
            rsp_diff_q <= '0;
            rsp_co_q   <= 1'b0;
        end else if (gnt_fire) begin
            last_gnt_q <= gnt_idx;
            rsp_id_q   <= gnt_idx;
            rsp_diff_q <= sub_res[WIDTH-1:0];
            rsp_co_q   <= sub_res[WIDTH];
        end
    end

`ifdef EXP_SUB_STATS_EN
    logic [7:0] gnt_cnt0_q, gnt_cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q <= 8'd0;
            gnt_cnt1_q <= 8'd0;
        end else begin
            if (req0_ready) gnt_cnt0_q <= sat_inc(gnt_cnt0_q);
            if (req1_ready) gnt_cnt1_q <= sat_inc(gnt_cnt1_q);
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

    assign rsp_valid = (state_q == HOLD);
    assign rsp_id    = rsp_id_q;
    assign rsp_diff  = rsp_diff_q;
    assign rsp_co    = rsp_co_q;

endmodule

// File: doc/exp_sub_arbiter.md
EXP_SUB_ARBITER -- requirements
Module: exp_sub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, meaning the operand/difference width of the shared borrow-lookahead subtractor.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has operands.
REQ-005 SHALL have port req0_a, req0_b  input  WIDTH each  requester 0 minuend, subtrahend.
REQ-006 SHALL have port req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 SHALL have ports req1_valid, req1_a, req1_b, req1_ready  with the same directions, widths and meaning, for requester 1.
REQ-008 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port rsp_id  output  1  requester index that owns the result.
REQ-011 SHALL have port rsp_diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-012 SHALL have port rsp_co  output  1  carry-out of a + ~b + 1; 1 when a >= b unsigned (no borrow).

Function
REQ-013 SHALL instantiate one subtractor datapath, shared by both requesters, computing diff/co combinationally from the granted operands.
REQ-014 SHALL use states IDLE (rsp_valid=0) and HOLD (rsp_valid=1).
REQ-015 SHALL define accept_ok = !rsp_valid || rsp_ready; transfers happen only when accept_ok=1.
REQ-016 SHALL grant, when accept_ok=1: the sole valid requester; if both are valid, the requester not granted last (round-robin pointer last_gnt).
REQ-017 SHALL assert reqN_ready only for the granted requester; at most one ready per cycle; ready SHALL NOT depend on the other requester's ready.
REQ-018 On an accepted transfer, SHALL register diff, co and id at the next edge, set rsp_valid=1, and update last_gnt to the granted index; latency is 1 cycle, from accept edge to rsp_valid.
REQ-019 In HOLD with rsp_ready=0, rsp_diff, rsp_co and rsp_id SHALL stay stable, and both readies SHALL be 0.
REQ-020 In HOLD with rsp_ready=1 and a valid requester, SHALL pop and accept in the same cycle (back-to-back, 1 result/cycle); with no valid requester, SHALL go to IDLE.
REQ-021 SHALL not change last_gnt on cycles with no transfer.
REQ-022 Arithmetic boundaries: a=b -> diff=0, co=1; a=0, b=31 -> diff=1, co=0; a=31, b=0 -> diff=31, co=1.

Reset
REQ-023 On rst_n=0, SHALL asynchronously clear rsp_valid, rsp_id, rsp_diff and rsp_co to 0 and set last_gnt=1, so requester 0 wins the first contention.
REQ-024 SHALL drive req0_ready=req1_ready=0 while rst_n=0; a transaction held during reset SHALL be discarded.
REQ-025 SHALL allow the first accept on the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro EXP_SUB_STATS_EN defined, SHALL add outputs gnt_cnt0 and gnt_cnt1 (8 bits each): per-requester accept counters, saturating at 255, reset to 0.
REQ-027 Without EXP_SUB_STATS_EN, those ports and their counters SHALL not exist; all other behaviour is identical.

Verification
REQ-028 Single request: req0 a=20, b=15, rsp_ready=1 -> rsp_valid one cycle later, diff=5, co=1, id=0.
REQ-029 Contention after reset: both valid, req0 (3,7), req1 (9,9) -> req0 served first (diff=28, co=0, id=0), then req1 (diff=0, co=1, id=1); strictly alternating while both stay valid.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles with a result held -> outputs stable, both readies 0; rsp_ready=1 with req1 pending -> pop and accept in the same cycle.
REQ-031 Reset mid-operation: rst_n low while HOLD -> rsp_valid=0 immediately (no clock edge); after release, a contended request grants req0.
REQ-032 With EXP_SUB_STATS_EN: 300 req0 accepts and 2 req1 accepts -> gnt_cnt0=255, gnt_cnt1=2.
REQ-033 Sweep all 1024 (a,b) pairs through each requester -> diff=(a-b) mod 32 and co=(a>=b) every time.
